// File: rtl/test_vector_sequencer.sv
// Table-driven stimulus/response engine: issues stored vectors to one of CHANNELS
// ports over valid/ready, compares masked responses under a per-vector timeout.
module test_vector_sequencer #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 64,
  parameter int CHANNELS = 4,
  parameter int TIMEOUT  = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(CHANNELS),
  localparam int TW = $clog2(TIMEOUT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ld_en,
  input  logic [AW-1:0]             ld_addr,
  input  logic [WIDTH-1:0]          ld_stim,
  input  logic [WIDTH-1:0]          ld_exp,
  input  logic [WIDTH-1:0]          ld_mask,
  input  logic [CW-1:0]             ld_chan,
  input  logic [AW:0]               num_vec,
  input  logic                      start,
  input  logic                      stop_on_fail,
  output logic [CHANNELS-1:0]       stim_valid,
  output logic [WIDTH-1:0]          stim_data,
  input  logic [CHANNELS-1:0]       stim_ready,
  input  logic [CHANNELS-1:0]       rsp_valid,
  input  logic [CHANNELS*WIDTH-1:0] rsp_data,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic [15:0]               pass_count,
  output logic [15:0]               fail_count,
  output logic [AW-1:0]             first_fail_idx,
  output logic                      timeout_err,
  output logic [2:0]                state_dbg
);

  // Handshake: a stimulus transfer happens on the rising clock edge where
  // stim_valid[c] && stim_ready[c]; a response is taken on the edge where
  // rsp_valid[c] is high while waiting on channel c. Data must be valid with valid.

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_CHECK = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] stim_mem [DEPTH];
  logic [WIDTH-1:0] exp_mem  [DEPTH];
  logic [WIDTH-1:0] mask_mem [DEPTH];
  logic [CW-1:0]    chan_mem [DEPTH];

  logic [WIDTH-1:0] rd_stim;
  logic [WIDTH-1:0] rd_exp;
  logic [WIDTH-1:0] rd_mask;
  logic [CW-1:0]    rd_chan;

  logic [AW:0]      idx;
  logic [AW:0]      nv_q;
  logic [TW-1:0]    tcnt;
  logic             sof_q;
  logic             vec_ok_q;

  logic [WIDTH-1:0] rsp_word;
  logic             ready_hit;
  logic             rsp_accept;
  logic             rsp_match;
  logic             tcnt_last;
  logic             vec_timeout;
  logic             last_vec;

  // Table is plain storage with no reset so it survives an aborted run.
  always_ff @(posedge clk) begin
    if (ld_en && !busy) begin
      stim_mem[ld_addr] <= ld_stim;
      exp_mem[ld_addr]  <= ld_exp;
      mask_mem[ld_addr] <= ld_mask;
      chan_mem[ld_addr] <= ld_chan;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_FETCH) begin
      rd_stim <= stim_mem[idx[AW-1:0]];
      rd_exp  <= exp_mem[idx[AW-1:0]];
      rd_mask <= mask_mem[idx[AW-1:0]];
      rd_chan <= chan_mem[idx[AW-1:0]];
    end
  end

  always_comb begin
    rsp_word    = rsp_data[int'(rd_chan)*WIDTH +: WIDTH];
    ready_hit   = stim_ready[rd_chan];
    rsp_accept  = (state == S_WAIT) && rsp_valid[rd_chan];
    rsp_match   = ((rsp_word ^ rd_exp) & rd_mask) == '0;
    tcnt_last   = tcnt == TW'(TIMEOUT - 1);
    // The budget covers ISSUE and WAIT together; a response on the last cycle still counts.
    vec_timeout = ((state == S_ISSUE) || (state == S_WAIT)) && tcnt_last && !rsp_accept;
    last_vec    = idx == (nv_q - 1'b1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_next = (num_vec == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_next = S_ISSUE;
      S_ISSUE: begin
        if (vec_timeout) begin
          state_next = S_CHECK;
        end else if (ready_hit) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_accept || vec_timeout) begin
          state_next = S_CHECK;
        end
      end
      S_CHECK: begin
        if (last_vec || (!vec_ok_q && sof_q)) begin
          state_next = S_DONE;
        end else begin
          state_next = S_FETCH;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx            <= '0;
      nv_q           <= '0;
      tcnt           <= '0;
      sof_q          <= 1'b0;
      vec_ok_q       <= 1'b0;
      pass_count     <= '0;
      fail_count     <= '0;
      first_fail_idx <= '0;
      timeout_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx            <= '0;
            nv_q           <= num_vec;
            sof_q          <= stop_on_fail;
            pass_count     <= '0;
            fail_count     <= '0;
            first_fail_idx <= '0;
            timeout_err    <= 1'b0;
          end
        end
        S_FETCH: tcnt <= '0;
        S_ISSUE, S_WAIT: begin
          tcnt     <= tcnt + 1'b1;
          vec_ok_q <= rsp_accept && rsp_match;
          if (vec_timeout) begin
            timeout_err <= 1'b1;
          end
        end
        S_CHECK: begin
          if (vec_ok_q) begin
            if (pass_count != 16'hFFFF) begin
              pass_count <= pass_count + 16'd1;
            end
          end else begin
            if (fail_count == '0) begin
              first_fail_idx <= idx[AW-1:0];
            end
            if (fail_count != 16'hFFFF) begin
              fail_count <= fail_count + 16'd1;
            end
          end
          if (state_next == S_FETCH) begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    stim_valid = '0;
    stim_data  = '0;
    if (state == S_ISSUE) begin
      stim_valid[rd_chan] = 1'b1;
      stim_data           = rd_stim;
    end
    busy      = (state == S_FETCH) || (state == S_ISSUE) || (state == S_WAIT) || (state == S_CHECK);
    done      = state == S_DONE;
    pass      = (state == S_DONE) && (fail_count == '0);
    state_dbg = state;
  end

endmodule

// File: tb/tb_test_vector_sequencer.sv
// Bench for test_vector_sequencer: a channel responder driven by per-vector plans,
// with expected issue order and run results derived from the vector table.
module tb_test_vector_sequencer;
  localparam int WIDTH    = 32;
  localparam int DEPTH    = 64;
  localparam int CHANNELS = 4;
  localparam int TIMEOUT  = 16;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CHANNELS);

  logic clk = 1'b0;
  logic reset;
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [WIDTH-1:0] ld_stim, ld_exp, ld_mask;
  logic [CW-1:0] ld_chan;
  logic [AW:0] num_vec;
  logic start, stop_on_fail;
  logic [CHANNELS-1:0] stim_valid, stim_ready, rsp_valid;
  logic [WIDTH-1:0] stim_data;
  logic [CHANNELS*WIDTH-1:0] rsp_data;
  logic busy, done, pass, timeout_err;
  logic [15:0] pass_count, fail_count;
  logic [AW-1:0] first_fail_idx;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  test_vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CHANNELS(CHANNELS), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_addr(ld_addr), .ld_stim(ld_stim),
    .ld_exp(ld_exp), .ld_mask(ld_mask), .ld_chan(ld_chan), .num_vec(num_vec),
    .start(start), .stop_on_fail(stop_on_fail), .stim_valid(stim_valid),
    .stim_data(stim_data), .stim_ready(stim_ready), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .busy(busy), .done(done), .pass(pass),
    .pass_count(pass_count), .fail_count(fail_count), .first_fail_idx(first_fail_idx),
    .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // Mirror of what the table should hold, and how the responder treats each vector.
  logic [WIDTH-1:0] m_stim [DEPTH];
  logic [WIDTH-1:0] m_exp  [DEPTH];
  logic [WIDTH-1:0] m_mask [DEPTH];
  int               m_chan [DEPTH];
  int               p_rdy  [DEPTH];
  int               p_dly  [DEPTH];
  bit               p_send [DEPTH];
  logic [WIDTH-1:0] p_rsp  [DEPTH];

  logic [WIDTH-1:0] exp_q[$];
  int exp_chan_q[$];
  int exp_len_q[$];
  int e_pass, e_fail, e_ffi;
  bit e_tmo;

  int ep, vi, iss, wcnt, cur_ch;
  bit in_wait;
  logic [CHANNELS-1:0] prev_sv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic load(input int a, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] e,
                      input logic [WIDTH-1:0] m, input int ch);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = AW'(a); ld_stim = s; ld_exp = e; ld_mask = m; ld_chan = CW'(ch);
    @(negedge clk);
    ld_en = 1'b0;
    m_stim[a] = s; m_exp[a] = e; m_mask[a] = m; m_chan[a] = ch;
  endtask

  // A response is only sent when it can land inside the cycle budget of the vector.
  task automatic set_plan(input int v, input int rdy, input int dly, input logic [WIDTH-1:0] rsp);
    p_rdy[v] = rdy; p_dly[v] = dly; p_rsp[v] = rsp;
    p_send[v] = (rdy + dly) <= (TIMEOUT - 2);
  endtask

  task automatic build_model(input int n, input bit sof);
    bit ok;
    exp_q.delete(); exp_chan_q.delete(); exp_len_q.delete();
    e_pass = 0; e_fail = 0; e_ffi = 0; e_tmo = 0;
    for (int v = 0; v < n; v++) begin
      exp_q.push_back(m_stim[v]);
      exp_chan_q.push_back(m_chan[v]);
      exp_len_q.push_back((p_rdy[v] + 1 < TIMEOUT) ? p_rdy[v] + 1 : TIMEOUT);
      ok = p_send[v] && (((p_rsp[v] ^ m_exp[v]) & m_mask[v]) == '0);
      if (!p_send[v]) e_tmo = 1'b1;
      if (ok) e_pass++;
      else begin
        if (e_fail == 0) e_ffi = v;
        e_fail++;
      end
      if (!ok && sof) break;
    end
  endtask

  task automatic responder();
    logic [CHANNELS-1:0] sv, tmask;
    logic [WIDTH-1:0] exp_stim;
    int exp_len;
    exp_stim = '0; exp_len = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stim_ready = '0; rsp_valid = '0; prev_sv = '0; in_wait = 1'b0;
        continue;
      end
      sv = stim_valid;
      if (sv != '0 && prev_sv == '0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", 64'd1, 64'd0);
          exp_stim = '0; cur_ch = 0; exp_len = 0;
        end else begin
          exp_stim = exp_q.pop_front();
          cur_ch   = exp_chan_q.pop_front();
          exp_len  = exp_len_q.pop_front();
        end
        vi = ep % DEPTH; iss = 0; in_wait = 1'b0;
      end
      tmask = '0; tmask[cur_ch] = 1'b1;
      stim_ready = CHANNELS'($urandom) & ~tmask;
      rsp_valid  = CHANNELS'($urandom) & ~tmask;
      for (int c = 0; c < CHANNELS; c++) rsp_data[c*WIDTH +: WIDTH] = $urandom;
      if (sv != '0) begin
        check("stim_valid", sv, tmask);
        check("stim_data", stim_data, exp_stim);
        rsp_valid[cur_ch] = 1'($urandom_range(0, 1));
        if (iss == p_rdy[vi]) begin
          stim_ready[cur_ch] = 1'b1; in_wait = 1'b1; wcnt = 0;
        end
        iss++;
      end else begin
        if (prev_sv != '0) begin
          check("issue_len", iss, exp_len);
          ep++;
        end
        if (in_wait) begin
          if (p_send[vi] && wcnt == p_dly[vi]) begin
            rsp_valid[cur_ch] = 1'b1;
            rsp_data[cur_ch*WIDTH +: WIDTH] = p_rsp[vi];
            in_wait = 1'b0;
          end
          wcnt++;
        end
      end
      prev_sv = sv;
    end
  endtask

  task automatic run(input int n, input bit sof, input bit poke, input string tag);
    int t;
    build_model(n, sof);
    ep = 0; in_wait = 1'b0;
    @(negedge clk);
    num_vec = (AW+1)'(n); stop_on_fail = sof; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_busy"}, busy, n != 0);
    if (n != 0) begin
      check({tag, "_valid_early"}, stim_valid, '0);
      @(negedge clk);
      check({tag, "_valid_2cyc"}, stim_valid != '0, 1'b1);
    end else begin
      check({tag, "_done_next"}, done, 1'b1);
    end
    if (poke) begin
      repeat (3) @(negedge clk);
      start = 1'b1; ld_en = 1'b1; ld_addr = '0; ld_stim = $urandom; ld_exp = $urandom; ld_chan = 2'd3;
      @(negedge clk);
      start = 1'b0; ld_en = 1'b0;
    end
    t = 0;
    while (!done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_done"}, done, 1'b1);
    check({tag, "_busy_end"}, busy, 1'b0);
    check({tag, "_pass_count"}, pass_count, e_pass);
    check({tag, "_fail_count"}, fail_count, e_fail);
    check({tag, "_first_fail"}, first_fail_idx, e_ffi);
    check({tag, "_timeout_err"}, timeout_err, e_tmo);
    check({tag, "_pass"}, pass, e_fail == 0);
    check({tag, "_issued_all"}, exp_q.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stim_valid"}, stim_valid, '0);
    check({tag, "_stim_data"}, stim_data, '0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_pass"}, pass, 1'b0);
    check({tag, "_pass_count"}, pass_count, 16'd0);
    check({tag, "_fail_count"}, fail_count, 16'd0);
    check({tag, "_first_fail"}, first_fail_idx, '0);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
  endtask

  initial begin
    int t, n;
    logic [WIDTH-1:0] e, m, r;
    reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_stim = '0; ld_exp = '0; ld_mask = '0; ld_chan = '0;
    num_vec = '0; start = 1'b0; stop_on_fail = 1'b0;
    stim_ready = '0; rsp_valid = '0; rsp_data = '0;
    ep = 0; vi = 0; iss = 0; wcnt = 0; cur_ch = 0; in_wait = 1'b0; prev_sv = '0;
    for (int i = 0; i < DEPTH; i++) set_plan(i, 0, 0, '0);
    fork
      responder();
    join_none
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;

    // Partial mask, noise on other channels while waiting.
    load(0, 32'h55, 32'h0000ABCD, 32'h0000FFFF, 1);
    set_plan(0, 0, 5, 32'hDEADABCD);
    run(1, 1'b0, 1'b0, "mask");
    check("mask_lit_pass", pass_count, 16'd1);

    for (int i = 0; i < 4; i++) begin
      load(i, 32'h11 * (i + 1), 32'h11 * (i + 1) + 1, 32'hFFFFFFFF, i);
      set_plan(i, 0, 0, 32'h11 * (i + 1) + 1);
    end
    run(4, 1'b0, 1'b0, "s1");
    check("s1_lit_pass", pass_count, 16'd4);
    check("s1_lit_fail", fail_count, 16'd0);

    set_plan(2, 0, 0, 32'h35);
    run(4, 1'b0, 1'b0, "s2");
    check("s2_lit_pass", pass_count, 16'd3);
    check("s2_lit_ffi", first_fail_idx, 6'd2);
    run(4, 1'b1, 1'b0, "s2sof");
    check("s2sof_lit_pass", pass_count, 16'd2);
    set_plan(2, 0, 0, 32'h34);

    set_plan(1, 20, 0, 32'h23);
    run(4, 1'b0, 1'b0, "tmo");
    check("tmo_lit_err", timeout_err, 1'b1);
    check("tmo_lit_pass", pass_count, 16'd3);
    set_plan(1, 0, 0, 32'h23);

    set_plan(0, 0, 14, 32'h12);
    run(1, 1'b0, 1'b0, "last_cycle");
    check("last_cycle_lit", pass_count, 16'd1);
    set_plan(0, 0, 15, 32'h12);
    run(1, 1'b0, 1'b0, "late");
    check("late_lit", timeout_err, 1'b1);
    set_plan(0, 15, 0, 32'h12);
    run(2, 1'b0, 1'b0, "rdy_last");
    set_plan(0, 0, 0, 32'h12);

    run(0, 1'b0, 1'b0, "zero");
    check("zero_lit_pass", pass, 1'b1);

    run(4, 1'b0, 1'b1, "poke");
    run(4, 1'b0, 1'b0, "after_poke");

    // Abort during the wait phase of vector 2, then rerun on the preserved table.
    set_plan(2, 0, 8, 32'h34);
    build_model(4, 1'b0);
    ep = 0; in_wait = 1'b0;
    @(negedge clk);
    num_vec = 7'd4; stop_on_fail = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while (!(vi == 2 && in_wait && stim_valid == '0) && t < 200);
    check("abort_reached_wait", t < 200, 1'b1);
    #2 reset = 1'b1;
    #1 check_zero("abort");
    repeat (2) @(negedge clk);
    reset = 1'b0;
    set_plan(2, 0, 0, 32'h34);
    run(4, 1'b0, 1'b0, "rerun");
    check("rerun_lit_pass", pass_count, 16'd4);

    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 16; i++) begin
        case ($urandom_range(0, 3))
          0: m = '0;
          1: m = '1;
          default: m = $urandom;
        endcase
        e = $urandom;
        load(i, $urandom, e, m, $urandom_range(0, CHANNELS - 1));
        r = ($urandom_range(0, 2) != 0) ? (e ^ (WIDTH'($urandom) & ~m)) : (e ^ WIDTH'($urandom));
        set_plan(i, ($urandom_range(0, 9) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 4),
                 $urandom_range(0, 8), r);
      end
      n = $urandom_range(1, 16);
      run(n, 1'($urandom_range(0, 1)), 1'b0, "rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
